// File: rtl/maxpool_pkg.sv
// -----------------------------------------------------------------------------
// maxpool_pkg
// Shared constants and types for the max-pooling stage that sits behind the
// convolution block.
//   DEF_WIDTH / DEF_LENY / DEF_POOL : default sample width, frame length and
//                                     pooling group size
//   sample_t                        : signed sample at the default width
//   fifo_entry_t                    : output FIFO entry (data, plus a frame-last
//                                     flag when MAXPOOL_LAST_EN is defined)
//   cnt_width()                     : counter width for a 0..range-1 counter
// Optional feature macro: MAXPOOL_LAST_EN
// -----------------------------------------------------------------------------
package maxpool_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_LENY  = 28;
  localparam int DEF_POOL  = 2;

  typedef logic signed [DEF_WIDTH-1:0] sample_t;

  typedef struct packed {
    sample_t data;
`ifdef MAXPOOL_LAST_EN
    logic    last;
`endif
  } fifo_entry_t;

  // A counter over 0..range-1 needs $clog2(range) bits; keep at least one bit
  // so degenerate ranges still give a legal vector.
  function automatic int cnt_width(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/maxpool_out_fifo.sv
// -----------------------------------------------------------------------------
// maxpool_out_fifo
// Two-entry valid/ready FIFO holding pooled results. Entry type is a parameter
// so the top can store data alone or data plus the frame-last flag
// (MAXPOOL_LAST_EN).
//   clk, reset   : clock, asynchronous active-low reset
//   push         : write push_entry (ignored when full)
//   push_entry   : entry to write
//   full         : both slots occupied (registered state)
//   pop_ready    : downstream ready; head leaves when valid && pop_ready
//   valid        : FIFO holds at least one entry
//   head         : oldest entry, held steady until it is popped
// -----------------------------------------------------------------------------
module maxpool_out_fifo
  import maxpool_pkg::*;
#(
  parameter type entry_t = fifo_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_entry,
  output logic   full,
  input  logic   pop_ready,
  output logic   valid,
  output entry_t head
);

  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign valid   = (count != 2'd0);
  assign full    = (count == 2'd2);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = valid && pop_ready;

  // Storage is cleared on reset so the head reads zero while empty after reset.
  // A simultaneous push and pop moves both pointers and leaves the count alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/maxpool_28_2_32.sv
// -----------------------------------------------------------------------------
// maxpool_28_2_32
// Streaming 1-D max pooling: every POOL accepted samples (or fewer at the end
// of a LENY-sample frame) produce one signed maximum. Groups never straddle a
// frame boundary.
//   clk           : clock, rising edge
//   reset         : asynchronous active-low reset
//   s_data_in_y   : signed input sample (WIDTH)
//   s_valid_y     : input sample valid
//   s_ready_y     : block can take a sample (registered state only)
//   m_data_out_p  : pooled maximum (WIDTH)
//   m_valid_p     : pooled output valid
//   m_ready_p     : downstream ready
//   m_last_p      : final pooled output of a frame (only with MAXPOOL_LAST_EN)
// Optional feature macro: MAXPOOL_LAST_EN
// -----------------------------------------------------------------------------
module maxpool_28_2_32
  import maxpool_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LENY  = DEF_LENY,
  parameter int POOL  = DEF_POOL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data_in_y,
  input  logic             s_valid_y,
  output logic             s_ready_y,
`ifdef MAXPOOL_LAST_EN
  output logic             m_last_p,
`endif
  output logic [WIDTH-1:0] m_data_out_p,
  output logic             m_valid_p,
  input  logic             m_ready_p
);

  localparam int GW = cnt_width(POOL);
  localparam int FW = cnt_width(LENY);
  localparam logic [GW-1:0] GRP_LAST = GW'(POOL - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(LENY - 1);

  typedef struct packed {
    logic [WIDTH-1:0] data;
`ifdef MAXPOOL_LAST_EN
    logic             last;
`endif
  } entry_t;

  logic [GW-1:0]    grp_cnt;
  logic [FW-1:0]    frm_cnt;
  logic [WIDTH-1:0] max_q;
  logic [WIDTH-1:0] pooled;
  logic             frame_end;
  logic             closing;
  logic             accept;
  logic             push;
  logic             fifo_full;
  entry_t           push_entry;
  entry_t           head;

  assign frame_end = (frm_cnt == FRM_LAST);
  assign closing   = (grp_cnt == GRP_LAST) || frame_end;

  // Only a closing beat needs a FIFO slot, so a full FIFO stalls just that
  // beat. Built from registers alone to keep m_ready_p/s_valid_y off this path.
  assign s_ready_y = !fifo_full || !closing;
  assign accept    = s_valid_y && s_ready_y;
  assign push      = accept && closing;

  // The first sample of a group ignores the stale register contents.
  assign pooled = (grp_cnt == '0) ? s_data_in_y :
                  (($signed(s_data_in_y) > $signed(max_q)) ? s_data_in_y : max_q);

  always_comb begin
    push_entry      = '0;
    push_entry.data = pooled;
`ifdef MAXPOOL_LAST_EN
    push_entry.last = frame_end;
`endif
  end

  // Group/frame counters and the running maximum advance only on accepted
  // beats; the frame counter wrap also forces the group closed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grp_cnt <= '0;
      frm_cnt <= '0;
      max_q   <= '0;
    end else if (accept) begin
      max_q   <= pooled;
      grp_cnt <= closing ? '0 : grp_cnt + 1'b1;
      frm_cnt <= frame_end ? '0 : frm_cnt + 1'b1;
    end
  end

  maxpool_out_fifo #(
    .entry_t (entry_t)
  ) u_out_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .full       (fifo_full),
    .pop_ready  (m_ready_p),
    .valid      (m_valid_p),
    .head       (head)
  );

  assign m_data_out_p = head.data;
`ifdef MAXPOOL_LAST_EN
  assign m_last_p     = head.last;
`endif

endmodule

// File: doc/maxpool_28_2_32.md
MAXPOOL_28_2_32 -- requirements
Module: maxpool_28_2_32

Interface
REQ-001 Parameter WIDTH, default 32, sample width in bits (signed two's complement).
REQ-002 Parameter LENY, default 28, convolution outputs per frame (43-16+1).
REQ-003 Parameter POOL, default 2, samples per pooling group; legal range 2..8.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-006 s_data_in_y  input  WIDTH  signed sample from upstream convolution stage.
REQ-007 s_valid_y  input  1  upstream sample valid.
REQ-008 s_ready_y  output  1  block accepts sample; transfer when s_valid_y && s_ready_y at rising edge.
REQ-009 m_data_out_p  output  WIDTH  signed pooled maximum.
REQ-010 m_valid_p  output  1  pooled output valid.
REQ-011 m_ready_p  input  1  downstream ready; transfer when m_valid_p && m_ready_p at rising edge.

Function
REQ-012 Each accepted sample is counted by grp_cnt (0..POOL-1) and frm_cnt (0..LENY-1).
REQ-013 Sample with grp_cnt==0 loads max register directly; later samples replace max only if signed-greater.
REQ-014 A beat is "closing" when grp_cnt==POOL-1 or frm_cnt==LENY-1; closing beat pushes max(current, held) into output FIFO and resets grp_cnt to 0.
REQ-015 frm_cnt==LENY-1 on accepted beat wraps frm_cnt to 0; a partial final group (LENY mod POOL != 0) is emitted, never merged into next frame.
REQ-016 Pooled outputs per frame = ceil(LENY/POOL); 14 at defaults.
REQ-017 Output FIFO depth 2; m_valid_p = FIFO non-empty; m_data_out_p = FIFO head, stable while m_valid_p && !m_ready_p.
REQ-018 s_ready_y = !fifo_full || !closing, derived only from registered state (no combinational path from m_ready_p or s_valid_y).
REQ-019 Push and pop in the same cycle are both honoured; count unchanged; FIFO order preserved.
REQ-020 Latency: closing beat accepted at edge N -> m_valid_p high after edge N when FIFO was empty.
REQ-021 No transfer when s_valid_y low: counters, max register unchanged.
REQ-022 Comparison and output are full WIDTH; no saturation or truncation.

Reset
REQ-023 While reset low: m_valid_p=0, FIFO empty, grp_cnt=0, frm_cnt=0, max=0, m_data_out_p=0; s_ready_y=1 after release.
REQ-024 Reset mid-group or mid-frame discards partial max and queued outputs; first sample after release starts a new frame.

Configuration
REQ-025 Macro MAXPOOL_LAST_EN: when defined, output port m_last_p (1 bit) exists, stored alongside each FIFO entry, high exactly with the final pooled output of each frame.
REQ-026 Without MAXPOOL_LAST_EN: port m_last_p absent, FIFO entries WIDTH bits only; all other behaviour identical.

Structure
REQ-027 Package maxpool_pkg holds default WIDTH/LENY/POOL constants, sample typedef (signed WIDTH) and FIFO-entry struct (data, optional last).
REQ-028 Sub-module maxpool_out_fifo: 2-entry valid/ready FIFO, parameterised on entry type, instantiated once.
REQ-029 Counter widths are $clog2 of their ranges, computed from parameters.

Verification
REQ-030 Samples 5,-3 (POOL=2), m_ready_p=1 -> one output 5, m_valid_p one cycle after second accept.
REQ-031 Samples -7,-2 -> output -2 (signed compare check); 32'h7FFFFFFF,32'h80000000 -> 32'h7FFFFFFF.
REQ-032 Full frame 1..28 with LENY=28 -> outputs 2,4,...,28 (14 values), m_last_p high only on 28 when enabled.
REQ-033 LENY=5, POOL=2, samples 9,1,4,8,3 then 6,7 -> outputs 9,8,3 then 7; no cross-frame merge.
REQ-034 m_ready_p held low for 10 cycles under continuous s_valid_y -> exactly 2 outputs queued, s_ready_y low on next closing beat, no loss or duplicate after release; random valid/ready over 100 frames matches model.
REQ-035 Reset asserted after 3 samples of a frame -> m_valid_p drops immediately, next 28 samples yield a clean 14-output frame.
